axi4_write_channel_arbiter: RTL
===============================

# axi4_write_channel_arbiter

Shares one slave's AXI4 write address (AW) and write data (W) channels between NO_OF_MASTERS masters. It arbitrates AW requests round-robin and records each granted burst in an order FIFO. W beats are then routed from the masters strictly in AW-grant order. The block sits between the master-side interconnect ports and a single slave port. B responses are routed elsewhere and are outside this block.

## Interface
- NO_OF_MASTERS, 2: number of requesting masters (≥2)
- ADDRESS_WIDTH, 32: AW address width
- DATA_WIDTH, 32: W data width; strobe width is DATA_WIDTH/8
- ORDER_FIFO_DEPTH, 16: maximum granted bursts whose W data is not yet complete (power of 2)

Ports, one per master packed `[NO_OF_MASTERS-1:0]` with field vectors concatenated, master 0 in the LSBs:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- m_awvalid / m_awready  in / out  N  per-master AW handshake
- m_awid / m_awaddr / m_awlen / m_awsize / m_awburst  in  N×4 / N×ADDRESS_WIDTH / N×8 / N×3 / N×2  per-master AW fields
- s_awvalid  out  1  slave AW valid
- s_awready  in  1  slave AW ready
- s_awid / s_awaddr / s_awlen / s_awsize / s_awburst  out  4 / ADDRESS_WIDTH / 8 / 3 / 2  registered AW fields
- m_wvalid / m_wready / m_wlast  in / out / in  N  per-master W handshake and last
- m_wdata / m_wstrb  in  N×DATA_WIDTH / N×DATA_WIDTH/8  per-master W payload
- s_wvalid / s_wready  out / in  1  slave W handshake
- s_wdata / s_wstrb / s_wlast  out  DATA_WIDTH / DATA_WIDTH/8 / 1  slave W payload and last
- outstanding_count  out  $clog2(ORDER_FIFO_DEPTH)+1  current order-FIFO occupancy
- err_wlast  out  1  sticky flag: master's wlast disagreed with its awlen

## Operation
- AW FSM has two states, AW_IDLE and AW_HOLD. Reset enters AW_IDLE. rr_ptr resets to 0.
- AW_IDLE:
  - Grant goes to the first i, searching from rr_ptr and wrapping modulo N, with m_awvalid[i]=1.
  - A grant requires outstanding_count < ORDER_FIFO_DEPTH.
  - m_awready[winner] is asserted combinationally in that cycle; all other m_awready stay 0.
  - On the grant, the AW fields are captured into the output register and {winner, awlen} is pushed into the order FIFO.
  - rr_ptr becomes (winner+1) mod N. The FSM moves to AW_HOLD.
- AW_HOLD:
  - s_awvalid=1 and the s_aw* fields are held stable. All m_awready=0.
  - On s_awready, the FSM returns to AW_IDLE.
- No grant is given while the FIFO is full. A requesting master waits with m_awready=0.
- W routing:
  - The FIFO head {idx, len} selects the source master.
  - s_wvalid=m_wvalid[idx], s_wdata=m_wdata[idx], s_wstrb=m_wstrb[idx].
  - m_wready[idx]=s_wready; all other m_wready=0.
  - If the FIFO is empty: s_wvalid=0 and all m_wready=0.
  - W data may reach the slave before the AW handshake completes; AXI4 permits this.
- Beat counter (8 bits, reset 0):
  - Increments on each s_wvalid&&s_wready.
  - s_wlast is regenerated as (beat_cnt==len). The master's wlast is not forwarded.
  - On the last-beat handshake the FIFO pops and beat_cnt clears to 0.
- err_wlast sets on any accepted beat where m_wlast[idx] != (beat_cnt==len). It clears only on reset.
- Simultaneous push and pop: occupancy is unchanged, and both operations take effect.
- Reset asserted mid-burst: all state clears immediately and in-flight bursts are discarded.
- Outputs while areset=1: s_awvalid=0, all s_aw* fields=0, m_awready=0, s_wvalid=0, m_wready=0, s_wlast=0, outstanding_count=0, err_wlast=0.

## Timing
- AW latency: a grant in cycle T gives s_awvalid=1 in cycle T+1. Peak throughput is one AW every 2 cycles.
- The W path is fully combinational from the master's W ports through the FIFO head to the slave W ports. Only the FIFO, beat_cnt and the flag are registered.
- The first W beat of a burst can transfer in the cycle after its grant.
- After a pop, the next burst's first beat can transfer in the following cycle with no bubble.
- outstanding_count updates in the cycle after a push or pop.

## Test plan
- Reset: areset=1 with random inputs -> every listed output is 0. After release, master 0 (awvalid, awlen=3) -> m_awready[0]=1 in the same cycle, s_awvalid=1 in the next cycle.
- Round-robin fairness: N=2, both masters hold awvalid continuously -> grants alternate 0,1,0,1. outstanding_count rises 1,2,3,4 while W is idle.
- W ordering: master 1 is granted awlen=1, then master 0 is granted awlen=0. Both drive W early -> slave sees 2 beats from master 1 (s_wlast on the 2nd), then 1 beat from master 0. m_wready[0] stays 0 until master 1's burst pops.
- Full FIFO: 16 grants with s_wready=0 -> outstanding_count=16 and the 17th request gets no m_awready. One burst completes -> the grant occurs the cycle after the count drops to 15.
- Simultaneous push and pop: a grant in the same cycle as a last-beat pop -> outstanding_count unchanged.
- err_wlast and mid-burst reset: awlen=2 with master wlast on beat 1 -> err_wlast=1 and stays 1. areset pulse during the burst -> err_wlast=0, FIFO empty, s_wvalid=0.

Source files
------------

// File: rtl/axi4_write_channel_arbiter_if.sv
// AW/W bus bundle between N masters, the write-channel arbiter and one slave.
// The arbiter takes the slave modport; the master modport faces the interconnect/bench.
interface axi4_write_channel_arbiter_if #(
    parameter int unsigned NO_OF_MASTERS = 2,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [NO_OF_MASTERS-1:0]               m_awvalid;
    logic [NO_OF_MASTERS-1:0]               m_awready;
    logic [NO_OF_MASTERS*4-1:0]             m_awid;
    logic [NO_OF_MASTERS*ADDRESS_WIDTH-1:0] m_awaddr;
    logic [NO_OF_MASTERS*8-1:0]             m_awlen;
    logic [NO_OF_MASTERS*3-1:0]             m_awsize;
    logic [NO_OF_MASTERS*2-1:0]             m_awburst;

    logic                     s_awvalid;
    logic                     s_awready;
    logic [3:0]               s_awid;
    logic [ADDRESS_WIDTH-1:0] s_awaddr;
    logic [7:0]               s_awlen;
    logic [2:0]               s_awsize;
    logic [1:0]               s_awburst;

    logic [NO_OF_MASTERS-1:0]            m_wvalid;
    logic [NO_OF_MASTERS-1:0]            m_wready;
    logic [NO_OF_MASTERS-1:0]            m_wlast;
    logic [NO_OF_MASTERS*DATA_WIDTH-1:0] m_wdata;
    logic [NO_OF_MASTERS*STRB_WIDTH-1:0] m_wstrb;

    logic                  s_wvalid;
    logic                  s_wready;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic [STRB_WIDTH-1:0] s_wstrb;
    logic                  s_wlast;

    modport slave (
        input  m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
        output m_awready,
        output s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
        input  s_awready,
        input  m_wvalid, m_wlast, m_wdata, m_wstrb,
        output m_wready,
        output s_wvalid, s_wdata, s_wstrb, s_wlast,
        input  s_wready
    );

    modport master (
        output m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
        input  m_awready,
        input  s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
        output s_awready,
        output m_wvalid, m_wlast, m_wdata, m_wstrb,
        input  m_wready,
        input  s_wvalid, s_wdata, s_wstrb, s_wlast,
        output s_wready
    );
endinterface

// File: rtl/axi4_write_channel_arbiter.sv
// Round-robin AW arbiter for N masters sharing one slave; W beats follow AW grant
// order through an order FIFO, with wlast regenerated from the granted awlen.
module axi4_write_channel_arbiter #(
    parameter int unsigned NO_OF_MASTERS    = 2,
    parameter int unsigned ADDRESS_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ORDER_FIFO_DEPTH = 16
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    axi4_write_channel_arbiter_if.slave           bus,
    output logic [$clog2(ORDER_FIFO_DEPTH):0]     outstanding_count,
    output logic                                  err_wlast
);
    localparam int unsigned N      = NO_OF_MASTERS;
    localparam int unsigned IDX_W  = $clog2(N);
    localparam int unsigned PTR_W  = $clog2(ORDER_FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    typedef enum logic {AW_IDLE, AW_HOLD} aw_state_e;

    aw_state_e        aw_state, aw_state_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0] winner;
    logic             win_found;
    logic             grant;

    logic [IDX_W-1:0] fifo_idx [ORDER_FIFO_DEPTH];
    logic [7:0]       fifo_len [ORDER_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full, fifo_empty;
    logic [IDX_W-1:0] sel_idx;
    logic [7:0]       head_len;
    logic [7:0]       beat_cnt;
    logic             last_beat, src_wlast, beat, pop;

    assign fifo_full         = (count == CNT_W'(ORDER_FIFO_DEPTH));
    assign fifo_empty        = (count == '0);
    assign outstanding_count = count;
    assign head_len          = fifo_len[rd_ptr];
    assign sel_idx           = fifo_empty ? '0 : fifo_idx[rd_ptr];

    // first requester at or after rr_ptr, wrapping
    always_comb begin
        int unsigned cand;
        cand      = 0;
        win_found = 1'b0;
        winner    = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(rr_ptr) + off) % N;
            if (!win_found && bus.m_awvalid[IDX_W'(cand)]) begin
                win_found = 1'b1;
                winner    = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        aw_state_nxt  = aw_state;
        rr_ptr_nxt    = rr_ptr;
        grant         = 1'b0;
        bus.m_awready = '0;
        bus.s_awvalid = 1'b0;
        case (aw_state)
            AW_IDLE: begin
                if (win_found && !fifo_full && !areset) begin
                    grant                 = 1'b1;
                    bus.m_awready[winner] = 1'b1;
                    rr_ptr_nxt            = IDX_W'((32'(winner) + 32'd1) % N);
                    aw_state_nxt          = AW_HOLD;
                end
            end
            AW_HOLD: begin
                bus.s_awvalid = 1'b1;
                if (bus.s_awready) aw_state_nxt = AW_IDLE;
            end
            default: aw_state_nxt = AW_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_state      <= AW_IDLE;
            rr_ptr        <= '0;
            bus.s_awid    <= '0;
            bus.s_awaddr  <= '0;
            bus.s_awlen   <= '0;
            bus.s_awsize  <= '0;
            bus.s_awburst <= '0;
        end else begin
            aw_state <= aw_state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            if (grant) begin
                bus.s_awid    <= bus.m_awid[32'(winner)*4 +: 4];
                bus.s_awaddr  <= bus.m_awaddr[32'(winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                bus.s_awlen   <= bus.m_awlen[32'(winner)*8 +: 8];
                bus.s_awsize  <= bus.m_awsize[32'(winner)*3 +: 3];
                bus.s_awburst <= bus.m_awburst[32'(winner)*2 +: 2];
            end
        end
    end

    // W path is purely combinational from the FIFO head's master
    always_comb begin
        bus.m_wready = '0;
        bus.s_wvalid = 1'b0;
        bus.s_wlast  = 1'b0;
        bus.s_wdata  = bus.m_wdata[32'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
        bus.s_wstrb  = bus.m_wstrb[32'(sel_idx)*STRB_W +: STRB_W];
        last_beat    = 1'b0;
        src_wlast    = 1'b0;
        if (!fifo_empty) begin
            last_beat             = (beat_cnt == head_len);
            bus.s_wvalid          = bus.m_wvalid[sel_idx];
            bus.m_wready[sel_idx] = bus.s_wready;
            bus.s_wlast           = last_beat;
            src_wlast             = bus.m_wlast[sel_idx];
        end
        beat = bus.s_wvalid && bus.s_wready;
        pop  = beat && last_beat;
    end

    always_ff @(posedge aclk) begin
        if (grant) begin
            fifo_idx[wr_ptr] <= winner;
            fifo_len[wr_ptr] <= bus.m_awlen[32'(winner)*8 +: 8];
        end
    end

    // occupancy: a push and a pop in the same cycle cancel out
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            beat_cnt  <= '0;
            err_wlast <= 1'b0;
        end else begin
            if (grant) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(grant) - CNT_W'(pop);
            if (beat) begin
                beat_cnt <= pop ? 8'd0 : beat_cnt + 8'd1;
                if (src_wlast != last_beat) err_wlast <= 1'b1;
            end
        end
    end
endmodule
